// File: rtl/bus_mem_ctrl_pkg.sv
// Shared encodings for the RV32I external-memory bus master:
// FSM states, bus SIZE codes, load/store funct3 codes and fault codes.
package bus_mem_ctrl_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        FLT_OK       = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_TIMEOUT  = 2'b10
    } fault_e;

    function automatic logic [1:0] size_code(input logic [2:0] funct3);
        logic [1:0] sz;
        case (funct3[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Illegal funct3 encodings are reported as misaligned: no bus cycle is issued.
    function automatic logic ls_bad_access(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = addr_lo[0];
            F3_W:        bad = (addr_lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/bus_mem_ctrl_load_align.sv
// Little-endian load lane select and sign/zero extension for RV32I loads.
module load_align
    import bus_mem_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = data[7:0];
            2'd1:    byte_sel = data[15:8];
            2'd2:    byte_sel = data[23:16];
            default: byte_sel = data[31:24];
        endcase
        half_sel = addr_lo[1] ? data[31:16] : data[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    rdata = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_H:    rdata = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_BU:   rdata = {{(XLEN-8){1'b0}}, byte_sel};
            F3_HU:   rdata = {{(XLEN-16){1'b0}}, half_sel};
            default: rdata = data;
        endcase
    end

endmodule

// File: rtl/bus_mem_ctrl.sv
// Multi-cycle bus master between the RV32I core and the external instruction/data
// memory pins: fetch and load/store sequencing, lane steering, fault and stall reporting.
module bus_mem_ctrl
    import bus_mem_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TIMEOUT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_req,
    input  logic [XLEN-1:0] fetch_addr,
    output logic [XLEN-1:0] instr,
    output logic            instr_vld,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [2:0]      ls_funct3,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic [XLEN-1:0] ls_rdata,
    output logic            ls_done,
    output logic [1:0]      ls_fault,
    output logic            stall,
    output logic [XLEN-1:0] IAD,
    input  logic [XLEN-1:0] IDT,
    input  logic            ACKI_n,
    output logic [XLEN-1:0] DAD,
    inout  wire  [XLEN-1:0] DDT,
    input  logic            ACKD_n,
    output logic            MREQ,
    output logic            WRITE,
    output logic [1:0]      SIZE
);

    // state   | meaning
    // S_IDLE  | waiting for fetch_req / ls_req (ls_req wins)
    // S_FETCH | IAD driven, waiting for ACKI_n
    // S_DATA  | MREQ driven, waiting for ACKD_n
    // S_DONE  | one-cycle ls_done with ls_fault

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [1:0]           state;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic [XLEN-1:0]      wdata_q;
    logic [2:0]           funct3_q;
    logic [XLEN-1:0]      wdata_lanes;
    logic [XLEN-1:0]      load_data;

    always_comb begin
        case (size_code(ls_funct3))
            SZ_BYTE: wdata_lanes = {4{ls_wdata[7:0]}};
            SZ_HALF: wdata_lanes = {2{ls_wdata[15:0]}};
            default: wdata_lanes = ls_wdata;
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3  (funct3_q),
        .addr_lo (DAD[1:0]),
        .data    (DDT),
        .rdata   (load_data)
    );

    assign MREQ    = (state == S_DATA);
    assign ls_done = (state == S_DONE);
    assign DDT     = (MREQ && WRITE) ? wdata_q : {XLEN{1'bz}};

    // Stall is combinational in S_IDLE so the very first request cycle already holds the core.
    always_comb begin
        case (state)
            S_IDLE:  stall = rst & (fetch_req | ls_req);
            S_DONE:  stall = 1'b0;
            default: stall = rst;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            instr     <= '0;
            instr_vld <= 1'b0;
            ls_rdata  <= '0;
            ls_fault  <= FLT_OK;
            IAD       <= '0;
            DAD       <= '0;
            WRITE     <= 1'b0;
            SIZE      <= SZ_WORD;
            wdata_q   <= '0;
            funct3_q  <= '0;
        end else begin
            instr_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (ls_req) begin
                        funct3_q <= ls_funct3;
                        if (ls_bad_access(ls_funct3, ls_addr[1:0])) begin
                            ls_fault <= FLT_MISALIGN;
                            state    <= S_DONE;
                        end else begin
                            DAD      <= ls_addr;
                            WRITE    <= ls_we;
                            SIZE     <= size_code(ls_funct3);
                            wdata_q  <= wdata_lanes;
                            ls_fault <= FLT_OK;
                            state    <= S_DATA;
                        end
                    end else if (fetch_req) begin
                        IAD   <= fetch_addr;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!ACKI_n) begin
                        instr     <= IDT;
                        instr_vld <= 1'b1;
                        state     <= S_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt   <= tmo_cnt + 1'b1;
                        instr     <= '0;
                        instr_vld <= 1'b1;
                        ls_fault  <= FLT_TIMEOUT;
                        state     <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (!ACKD_n) begin
                        if (!WRITE) begin
                            ls_rdata <= load_data;
                        end
                        state <= S_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt  <= tmo_cnt + 1'b1;
                        ls_fault <= FLT_TIMEOUT;
                        state    <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Directed plus randomized bench for bus_mem_ctrl against a transaction-level reference model.
module tb_bus_mem_ctrl;

    localparam int TMO_WAITS = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic [31:0] instr;
    logic        instr_vld;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [2:0]  ls_funct3 = '0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic [1:0]  ls_fault;
    logic        stall;
    logic [31:0] IAD;
    logic [31:0] IDT = '0;
    logic        ACKI_n = 1'b1;
    logic [31:0] DAD;
    wire  [31:0] ddt;
    logic        ACKD_n = 1'b1;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;

    logic        mem_oe = 1'b0;
    logic [31:0] mem_drv = '0;
    assign ddt = mem_oe ? mem_drv : 32'hzzzzzzzz;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bus_mem_ctrl #(.XLEN(32), .TIMEOUT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .instr      (instr),
        .instr_vld  (instr_vld),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_funct3  (ls_funct3),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_rdata   (ls_rdata),
        .ls_done    (ls_done),
        .ls_fault   (ls_fault),
        .stall      (stall),
        .IAD        (IAD),
        .IDT        (IDT),
        .ACKI_n     (ACKI_n),
        .DAD        (DAD),
        .DDT        (ddt),
        .ACKD_n     (ACKD_n),
        .MREQ       (MREQ),
        .WRITE      (WRITE),
        .SIZE       (SIZE)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference model: plain arithmetic over the architectural rules.
    function automatic bit ref_bad(input int f3, input logic [31:0] a);
        if (f3 == 3 || f3 >= 6) return 1'b1;
        if (f3 == 1 || f3 == 5) return (a % 2) != 0;
        if (f3 == 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_size(input int f3);
        if (f3 % 4 == 0) return 32'd3;
        if (f3 % 4 == 1) return 32'd1;
        return 32'd0;
    endfunction

    function automatic logic [31:0] ref_lanes(input int f3, input logic [31:0] w);
        if (f3 % 4 == 0) return (w & 32'hFF) * 32'h01010101;
        if (f3 % 4 == 1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input int f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        v = d >> (8 * (a % 4));
        case (f3)
            0: return (v & 32'hFF) | (((v & 32'h80) != 0) ? 32'hFFFFFF00 : 32'h0);
            1: return (v & 32'hFFFF) | (((v & 32'h8000) != 0) ? 32'hFFFF0000 : 32'h0);
            4: return v & 32'hFF;
            5: return v & 32'hFFFF;
            default: return d;
        endcase
    endfunction

    // n_ack: S_FETCH cycle (1-based) in which ACKI_n goes low; >TMO_WAITS means never.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] idt, input int n_ack, input string tag);
        int lat;
        bit tmo;
        tmo = (n_ack > TMO_WAITS);
        fetch_req = 1'b1;
        fetch_addr = addr;
        #1;
        chk({tag, "_stall_req"}, 32'(stall), 32'd1);
        step();
        fetch_req = 1'b0;
        fetch_addr = $urandom;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (instr_vld) begin
                lat = k;
                break;
            end
            if (k == 1) begin
                chk({tag, "_iad"}, IAD, addr);
                chk({tag, "_stall_wait"}, 32'(stall), 32'd1);
            end
            if (k == n_ack) begin
                ACKI_n = 1'b0;
                IDT = idt;
            end
            step();
            ACKI_n = 1'b1;
            IDT = $urandom;
        end
        chk({tag, "_latency"}, 32'(lat), tmo ? 32'(TMO_WAITS + 1) : 32'(n_ack + 1));
        chk({tag, "_instr"}, instr, tmo ? 32'h0 : idt);
        chk({tag, "_ls_done"}, 32'(ls_done), 32'(tmo));
        if (tmo) chk({tag, "_fault"}, 32'(ls_fault), 32'd2);
        step();
        chk({tag, "_vld_pulse"}, 32'(instr_vld), 32'd0);
    endtask

    task automatic do_ls(input bit we, input int f3, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] bus, input int n_ack, input string tag);
        int lat;
        bit bad, tmo, mreq_seen;
        logic [31:0] lanes;
        bad = ref_bad(f3, addr);
        tmo = !bad && (n_ack > TMO_WAITS);
        lanes = ref_lanes(f3, wdata);
        ls_req = 1'b1;
        ls_we = we;
        ls_funct3 = 3'(f3);
        ls_addr = addr;
        ls_wdata = wdata;
        #1;
        chk({tag, "_stall_req"}, 32'(stall), 32'd1);
        mreq_seen = MREQ;
        step();
        ls_req = 1'b0;
        ls_we = 1'($urandom);
        ls_funct3 = 3'($urandom);
        ls_addr = $urandom;
        ls_wdata = $urandom;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            mreq_seen = mreq_seen | MREQ;
            if (ls_done) begin
                lat = k;
                break;
            end
            if (k == 1) begin
                chk({tag, "_mreq"}, 32'(MREQ), 32'd1);
                chk({tag, "_dad"}, DAD, addr);
                chk({tag, "_write"}, 32'(WRITE), 32'(we));
                chk({tag, "_size"}, 32'(SIZE), ref_size(f3));
                if (we) chk({tag, "_ddt_lanes"}, ddt, lanes);
            end
            if (k == n_ack) begin
                ACKD_n = 1'b0;
                if (!we) begin
                    mem_oe = 1'b1;
                    mem_drv = bus;
                end
            end
            step();
            ACKD_n = 1'b1;
            mem_oe = 1'b0;
        end
        chk({tag, "_latency"}, 32'(lat), bad ? 32'd1 : (tmo ? 32'(TMO_WAITS + 1) : 32'(n_ack + 1)));
        chk({tag, "_fault"}, 32'(ls_fault), bad ? 32'd1 : (tmo ? 32'd2 : 32'd0));
        chk({tag, "_stall_done"}, 32'(stall), 32'd0);
        if (bad) chk({tag, "_no_mreq"}, 32'(mreq_seen), 32'd0);
        if (!we && !bad && !tmo) chk({tag, "_rdata"}, ls_rdata, ref_load(f3, addr, bus));
        step();
        chk({tag, "_done_pulse"}, 32'(ls_done), 32'd0);
        if (we && !bad) chk({tag, "_ddt_released"}, 32'(ddt === lanes), 32'd0);
    endtask

    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] st_f3 [3] = '{3'd0, 3'd1, 3'd2};
    logic [2:0] il_f3 [3] = '{3'd3, 3'd6, 3'd7};

    initial begin
        bit we, seen;
        int f3, n_ack, r;
        logic [31:0] addr, wd;

        // Reset values
        #12;
        chk("rst_instr", instr, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        chk("rst_iad", IAD, 32'h0);
        chk("rst_dad", DAD, 32'h0);
        chk("rst_ctl", 32'({instr_vld, ls_done, MREQ, WRITE, stall, ls_fault, SIZE}), 32'h0);
        step();
        rst = 1'b1;
        step();

        // 1: fetch with two wait states
        do_fetch(32'h100, 32'h00A00093, 3, "t1_fetch");
        // 2: LB sign extension, ACK on first S_DATA cycle
        do_ls(1'b0, 0, 32'h203, 32'h0, 32'h80FF1234, 1, "t2_lb");
        chk("t2_lb_value", ls_rdata, 32'hFFFFFF80);
        // 3: LHU upper half, SH lane replication
        do_ls(1'b0, 5, 32'h202, 32'h0, 32'h80FF1234, 1, "t3_lhu");
        chk("t3_lhu_value", ls_rdata, 32'h000080FF);
        do_ls(1'b1, 1, 32'h202, 32'h0000ABCD, 32'h0, 2, "t3_sh");
        // 4: misaligned LW
        do_ls(1'b0, 2, 32'h206, 32'h0, 32'h0, 1, "t4_lw_mis");
        // 5: store timeout, and ACK on the terminal-count cycle still succeeds
        do_ls(1'b1, 2, 32'h208, 32'hCAFEF00D, 32'h0, 99, "t5_sw_tmo");
        do_ls(1'b0, 2, 32'h20C, 32'h0, 32'h13579BDF, TMO_WAITS, "t5_lw_last");
        do_fetch(32'h104, 32'h12345678, 99, "t5_fetch_tmo");

        // ACK while idle is ignored
        ACKI_n = 1'b0;
        ACKD_n = 1'b0;
        step();
        ACKI_n = 1'b1;
        ACKD_n = 1'b1;
        chk("idle_ack_ignored", 32'({instr_vld, ls_done, MREQ}), 32'h0);

        // 6: simultaneous requests, data first
        fetch_req = 1'b1;
        fetch_addr = 32'h300;
        ls_req = 1'b1;
        ls_we = 1'b0;
        ls_funct3 = 3'd2;
        ls_addr = 32'h400;
        step();
        ls_req = 1'b0;
        chk("t6_data_first", 32'(MREQ), 32'd1);
        chk("t6_dad", DAD, 32'h400);
        ACKD_n = 1'b0;
        mem_oe = 1'b1;
        mem_drv = 32'h2468ACE0;
        step();
        ACKD_n = 1'b1;
        mem_oe = 1'b0;
        chk("t6_ls_done", 32'(ls_done), 32'd1);
        chk("t6_rdata", ls_rdata, 32'h2468ACE0);
        step();
        step();
        fetch_req = 1'b0;
        chk("t6_then_fetch_iad", IAD, 32'h300);
        ACKI_n = 1'b0;
        IDT = 32'hDEADBEEF;
        step();
        ACKI_n = 1'b1;
        chk("t6_fetch_vld", 32'(instr_vld), 32'd1);
        chk("t6_fetch_instr", instr, 32'hDEADBEEF);
        step();

        // 6: reset mid-S_DATA
        ls_req = 1'b1;
        ls_we = 1'b1;
        ls_funct3 = 3'd2;
        ls_addr = 32'h500;
        ls_wdata = 32'h5A5A5A5A;
        step();
        ls_req = 1'b0;
        chk("t6_store_mreq", 32'(MREQ), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_ctl", 32'({instr_vld, ls_done, MREQ, WRITE, stall, ls_fault, SIZE}), 32'h0);
        chk("t6_rst_addr", IAD | DAD, 32'h0);
        chk("t6_rst_data", instr | ls_rdata, 32'h0);
        chk("t6_rst_ddt_released", 32'(ddt === 32'h5A5A5A5A), 32'd0);
        step();
        rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            seen = seen | ls_done | instr_vld | MREQ;
        end
        chk("t6_no_done_after_rst", 32'(seen), 32'd0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r < 6) n_ack = $urandom_range(1, 4);
            else if (r < 7) n_ack = TMO_WAITS;
            else if (r < 8) n_ack = TMO_WAITS + 1;
            else n_ack = $urandom_range(5, 14);
            if ($urandom_range(0, 9) < 3) begin
                do_fetch($urandom & 32'hFFFFFFFC, $urandom, n_ack, "rnd_fetch");
            end else begin
                we = 1'($urandom_range(0, 1));
                f3 = we ? int'(st_f3[$urandom_range(0, 2)]) : int'(ld_f3[$urandom_range(0, 4)]);
                if ($urandom_range(0, 9) == 0) f3 = int'(il_f3[$urandom_range(0, 2)]);
                addr = $urandom;
                if ($urandom_range(0, 2) != 0) addr = addr & ~((f3 % 4 == 2) ? 32'h3 : 32'h1);
                wd = $urandom | 32'h1;
                do_ls(we, f3, addr, wd, $urandom, n_ack, we ? "rnd_store" : "rnd_load");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
